// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for a shared single-cycle ALU.
// Shifts by N are executed as N one-bit ALU passes.
module alu_op_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_err,
   output logic             busy,
   output logic [3:0]       alu_sel,
   output logic [WIDTH-1:0] alu_operand_0,
   output logic [WIDTH-1:0] alu_operand_1,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      SHIFT,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [3:0]       op_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] b_q;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] result_q;
   logic             err_q;

   logic           legal;
   logic           is_shift;
   logic [SHW-1:0] amt;
   logic           last;

   assign legal    = (req_op <= 4'd8);
   assign is_shift = (req_op == 4'd5) | (req_op == 4'd6) | (req_op == 4'd7);
   assign amt      = req_b[SHW-1:0];
   assign last     = (cnt == SHW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      busy          = 1'b1;
      alu_sel       = 4'd0;
      alu_operand_0 = '0;
      alu_operand_1 = '0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               if (!legal)                         state_nxt = DONE;
               else if (is_shift && amt == '0)     state_nxt = DONE;
               else if (is_shift)                  state_nxt = SHIFT;
               else                                state_nxt = EXEC;
            end
         end
         EXEC: begin
            alu_sel       = op_q;
            alu_operand_0 = acc;
            alu_operand_1 = b_q;
            state_nxt     = DONE;
         end
         SHIFT: begin
            alu_sel       = op_q;
            alu_operand_0 = acc;
            alu_operand_1 = WIDTH'(1);
            if (last) state_nxt = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
      endcase
   end

   // acc holds operand A for EXEC and the running value for SHIFT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= 4'd0;
         acc      <= '0;
         b_q      <= '0;
         cnt      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q  <= req_op;
                  acc   <= req_a;
                  b_q   <= req_b;
                  cnt   <= amt;
                  err_q <= ~legal;
                  if (!legal)                     result_q <= '0;
                  else if (is_shift && amt == '0) result_q <= req_a;
               end
            end
            EXEC: result_q <= alu_result;
            SHIFT: begin
               acc <= alu_result;
               cnt <= cnt - SHW'(1);
               if (last) result_q <= alu_result;
            end
            DONE: ;
         endcase
      end
   end

   assign rsp_result = result_q;
   assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: alu_op_sequencer driving a behavioural one-bit-shift ALU.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_err;
   logic        busy;
   logic [3:0]  alu_sel;
   logic [31:0] alu_operand_0;
   logic [31:0] alu_operand_1;
   logic [31:0] alu_result;

   int checks = 0;
   int errors = 0;
   int alu_cycles = 0;
   int ones;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op(req_op),
      .req_a(req_a),
      .req_b(req_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_result(rsp_result),
      .rsp_err(rsp_err),
      .busy(busy),
      .alu_sel(alu_sel),
      .alu_operand_0(alu_operand_0),
      .alu_operand_1(alu_operand_1),
      .alu_result(alu_result)
   );

   // shared ALU: shifts move one bit per operation
   always_comb begin
      alu_result = 32'd0;
      case (alu_sel)
         4'd0: alu_result = alu_operand_0 + alu_operand_1;
         4'd1: alu_result = alu_operand_0 - alu_operand_1;
         4'd2: alu_result = alu_operand_0 & alu_operand_1;
         4'd3: alu_result = alu_operand_0 | alu_operand_1;
         4'd4: alu_result = alu_operand_0 ^ alu_operand_1;
         4'd5: alu_result = alu_operand_0 << 1;
         4'd6: alu_result = alu_operand_0 >> 1;
         4'd7: alu_result = $signed(alu_operand_0) >>> 1;
         4'd8: alu_result = {31'd0,
                  $signed(alu_operand_0) < $signed(alu_operand_1)};
         default: alu_result = 32'd0;
      endcase
   end

   always @(posedge clk)
      if (alu_sel != 4'd0 || alu_operand_0 != 32'd0 || alu_operand_1 != 32'd0)
         alu_cycles++;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // issue one request with rsp_ready high, measure latency from edge 0
   task automatic run(input string tag, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic exp_e,
                      input int exp_lat, output int n_ones);
      int lat;
      lat = 0;
      n_ones = 0;
      req_op = op;
      req_a = a;
      req_b = b;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a = 32'hA5A5_A5A5;
      req_b = 32'h5A5A_5A5A;
      while (!rsp_valid && lat < 40) begin
         if (alu_operand_1 == 32'd1 && alu_sel == op) n_ones++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, 64'(rsp_result), 64'(exp_r));
      chk({tag, "_err"}, 64'(rsp_err), 64'(exp_e));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_op = 4'd0;
      req_a = 32'd0;
      req_b = 32'd0;
      rsp_ready = 1'b1;
      #3;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_result", 64'(rsp_result), 64'd0);
      chk("rst_err", 64'(rsp_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu", {28'd0, alu_sel, alu_operand_0 | alu_operand_1}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run("add", 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1, ones);
      run("sub", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1, ones);

      alu_cycles = 0;
      run("shl5", 4'd5, 32'd1, 32'd5, 32'h20, 1'b0, 5, ones);
      chk("shl5_op1_ones", 64'(ones), 64'd5);
      chk("shl5_alu_cycles", 64'(alu_cycles), 64'd5);

      run("sra31", 4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 31, ones);
      run("srl31", 4'd6, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 31, ones);

      alu_cycles = 0;
      run("shl0", 4'd5, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0, 0, ones);
      chk("shl0_no_alu", 64'(alu_cycles), 64'd0);

      run("lt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, ones);
      run("lt_pos", 4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, ones);

      run("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1, ones);
      run("illegal", 4'hA, 32'd3, 32'd4, 32'd0, 1'b1, 0, ones);
      run("after_ill", 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1, ones);

      // backpressure: response held while a second request waits
      rsp_ready = 1'b0;
      req_op = 4'd0;
      req_a = 32'd2;
      req_b = 32'd3;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_op = 4'd4;
      req_a = 32'd12;
      req_b = 32'd10;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_result", 64'(rsp_result), 64'd5);
         chk("bp_err", 64'(rsp_err), 64'd0);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      chk("bp_still_valid", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_ready", 64'(req_ready), 64'd1);
      chk("bp_idle_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("bp_accepted", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      chk("bp2_valid", 64'(rsp_valid), 64'd1);
      chk("bp2_result", 64'(rsp_result), 64'd6);
      @(posedge clk);
      #1;

      // reset in the middle of a 20-bit shift
      req_op = 4'd5;
      req_a = 32'd1;
      req_b = 32'd20;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_req_ready", 64'(req_ready), 64'd1);
      chk("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mrst_result", 64'(rsp_result), 64'd0);
      chk("mrst_err", 64'(rsp_err), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_alu", {28'd0, alu_sel, alu_operand_0 | alu_operand_1}, 64'd0);
      @(posedge clk);
      #1;
      chk("mrst_hold_valid", 64'(rsp_valid), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_after_valid", 64'(rsp_valid), 64'd0);
      run("add_after_rst", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1, ones);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
